// File: rtl/grid_line_clear.sv
// Playfield and score owner: writes locked pieces into the grid,
// compacts full rows downward, scores the clears and flags game over.
module grid_line_clear #(
   parameter int ROWS      = 20,
   parameter int COLS      = 10,
   parameter int SCORE_MAX = 999
) (
   input  logic                          Clk,
   input  logic                          Reset_n,
   input  logic                          clr,
   input  logic                          lock_valid,
   output logic                          lock_ready,
   input  logic [3:0][4:0]               lock_rows,
   input  logic [3:0][3:0]               lock_cols,
   input  logic [2:0]                    lock_color,
   output logic [ROWS-1:0][COLS-1:0][2:0] grid,
   output logic [9:0]                    score,
   output logic [2:0]                    lines_last,
   output logic                          busy,
   output logic                          game_over
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_SHIFT,
      S_SCORE
   } state_t;

   localparam logic [10:0] MAX11 = 11'(SCORE_MAX);
   localparam logic [4:0]  LAST  = 5'(ROWS - 1);

   state_t                         r_state;
   logic [4:0]                     r_ptr;
   logic [2:0]                     r_cnt;
   logic [ROWS-1:0][COLS-1:0][2:0] r_grid;
   logic [9:0]                     r_score;
   logic [2:0]                     r_lines;
   logic                           r_go;

   logic                           w_xfer;
   logic                           w_row_full;
   logic                           w_top_used;
   logic [3:0]                     w_add;
   logic [10:0]                    w_sum;
   logic [9:0]                     w_new_score;

   assign lock_ready = (r_state == S_IDLE) && !r_go;
   assign busy       = (r_state != S_IDLE);
   assign w_xfer     = lock_valid && lock_ready;
   assign grid       = r_grid;
   assign score      = r_score;
   assign lines_last = r_lines;
   assign game_over  = r_go;

   always_comb begin
      w_row_full = 1'b1;
      w_top_used = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         if (r_grid[r_ptr][c] == 3'd0) w_row_full = 1'b0;
         if (r_grid[0][c] != 3'd0)     w_top_used = 1'b1;
      end
   end

   // Counts above four cannot arise from a legal piece; score them as four.
   always_comb begin
      unique case (r_cnt)
         3'd0:    w_add = 4'd0;
         3'd1:    w_add = 4'd1;
         3'd2:    w_add = 4'd3;
         3'd3:    w_add = 4'd5;
         default: w_add = 4'd8;
      endcase
      w_sum       = {1'b0, r_score} + {7'd0, w_add};
      w_new_score = (w_sum > MAX11) ? MAX11[9:0] : w_sum[9:0];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
         r_ptr   <= LAST;
         r_cnt   <= 3'd0;
         r_grid  <= '0;
         r_score <= 10'd0;
         r_lines <= 3'd0;
         r_go    <= 1'b0;
      end else if (clr) begin
         r_state <= S_IDLE;
         r_ptr   <= LAST;
         r_cnt   <= 3'd0;
         r_grid  <= '0;
         r_score <= 10'd0;
         r_lines <= 3'd0;
         r_go    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  for (int i = 0; i < 4; i++) begin
                     if (lock_rows[i] < 5'(ROWS) &&
                         lock_cols[i] < 4'(COLS))
                        r_grid[lock_rows[i]][lock_cols[i]] <= lock_color;
                  end
                  r_ptr   <= LAST;
                  r_cnt   <= 3'd0;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_row_full)
                  r_state <= S_SHIFT;
               else if (r_ptr == 5'd0)
                  r_state <= S_SCORE;
               else
                  r_ptr <= r_ptr - 5'd1;
            end
            S_SHIFT: begin
               // Pointer is kept so the row that dropped in is rescanned.
               for (int k = 1; k < ROWS; k++) begin
                  if (5'(k) <= r_ptr)
                     r_grid[k] <= r_grid[k-1];
               end
               r_grid[0] <= '0;
               r_cnt     <= r_cnt + 3'd1;
               r_state   <= S_SCAN;
            end
            S_SCORE: begin
               r_score <= w_new_score;
               r_lines <= r_cnt;
               r_go    <= r_go | w_top_used;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
